ip_gpio_multi: RTL and testbench
================================

// Module: ip_gpio_multi
// PURPOSE
//  Parametrised multi-port GPIO on the MSX-50BUS I/O space; successor of the single-port 8-bit GPIO.
//  Provides PORTS 8-bit ports, each with output latch, per-bit direction, synchronised input,
//  rising-edge status (W1C) and interrupt enable, plus one combined level IRQ. Sits beside other ip_* bus slaves.
// PARAMETERS
//  IO_BASE      8'h10  first I/O address (addr[7:0]); multiple of 4; IO_BASE+4*PORTS-1 <= 8'hFF
//  PORTS        2      number of 8-bit ports, 1..8
//  SYNC_STAGES  2      input synchroniser depth, 2..4
// PORTS
//  clk             in   1          system clock
//  n_reset         in   1          asynchronous active-low reset
//  bus_address     in   16         I/O address; only [7:0] decoded, [15:8] ignored
//  bus_io_read     in   1          1-cycle I/O read strobe
//  bus_io_write    in   1          1-cycle I/O write strobe
//  bus_write_data  in   8          write data, valid with bus_io_write
//  bus_read_ready  out  1          1-cycle pulse: read data valid
//  bus_read_data   out  8          read data; 8'h00 when bus_read_ready=0
//  gpo             out  8*PORTS    output latches, port p at [8p+7:8p]
//  gpo_oe          out  8*PORTS    direction (1=drive output), same packing
//  gpi             in   8*PORTS    raw asynchronous pin inputs, same packing
//  irq             out  1          level IRQ = |(STAT & IEN) over all ports
// BEHAVIOUR
//  Register map, port p, offset o = addr[1:0] from IO_BASE+4p:
//   o=0 DATA  W: output latch.  R: per bit, dir=1 -> latch, dir=0 -> synchronised pin
//   o=1 DIR   R/W direction
//   o=2 STAT  R: rising-edge flags; W: write-1-to-clear
//   o=3 IEN   R/W interrupt enable per bit
//  Decode hit: addr[7:0] in [IO_BASE, IO_BASE+4*PORTS). Miss: writes ignored, no ready, data stays 00.
//  Reset (async): gpo, gpo_oe, STAT, IEN, sync chain = 0; bus_read_ready=0; bus_read_data=00; irq=0.
//  Write: strobe sampled at posedge N; register updated at that edge, visible on outputs from cycle N+1.
//  Read: strobe sampled at posedge N -> bus_read_ready=1 and bus_read_data valid during cycle N+1 only.
//   Exactly 1-cycle latency; no wait states; ready never asserted for a miss.
//  Read+write same cycle (any addresses): both honoured; read returns pre-write value.
//  Input path: SYNC_STAGES flops per bit; pin change appears in DATA read after SYNC_STAGES cycles.
//  Edge detect: sync_now & ~sync_prev & ~dir -> set STAT bit. Output-direction bits never set STAT.
//  STAT set and W1C clear same bit same cycle: set wins (bit stays 1). Writing 0 bits: no effect.
//  DIR 1->0 switch: sync_prev is not re-seeded; edge only on a real 0->1 of the synchronised pin.
//  irq registered: reflects STAT/IEN one cycle after they change; drops cycle after last flag cleared.
//  Reset mid-read: bus_read_ready drops immediately (async), pending read discarded.
// STRUCTURE
//  Package ip_gpio_pkg: register offset constants (GPIO_DATA=2'd0, GPIO_DIR, GPIO_STAT, GPIO_IEN),
//   max-ports constant, packed port-index helper.
//  Sub-module ip_gpio_port: one 8-bit port (latches, synchroniser, edge detect, W1C, local irq, read mux).
//  Top: address decode, generate loop over PORTS, read-data mux, ready pulse, irq OR, parameter checks.
// TESTING
//  1 Write 8'h12 to IO_BASE+0, 8'hFF to +1 -> gpo[7:0]=12, gpo_oe[7:0]=FF from next cycle; upper bytes 00.
//  2 Write port1 DATA addr 'hCD14 = 8'hAB (bits[15:8] ignored) -> gpo[15:8]=AB; read 'h0014 -> AB after 1 cycle.
//  3 DIR0=8'h0F, latch 8'hA5, gpi[7:0]=8'h3C, wait SYNC_STAGES+1 -> read DATA0 = 8'h35.
//  4 DIR0=00, IEN0=8'h01, gpi bit0 0->1 -> STAT0=01, irq=1; write STAT0=01 -> STAT0=00, irq=0 next cycle.
//  5 Pin rise on cycle of W1C to same bit -> STAT bit remains 1, irq stays 1.
//  6 Read 'h0002 / 'h0018 (PORTS=2) for 10 cycles -> bus_read_ready never 1; writes there change nothing.

Source files
------------

// File: rtl/ip_gpio_pkg.sv
// Shared constants and helpers for the multi-port GPIO.
package ip_gpio_pkg;

   // Register offsets inside one 4-byte port window
   localparam logic [1:0] GPIO_DATA = 2'd0;
   localparam logic [1:0] GPIO_DIR  = 2'd1;
   localparam logic [1:0] GPIO_STAT = 2'd2;
   localparam logic [1:0] GPIO_IEN  = 2'd3;

   // Upper bound on the number of ports (3-bit port index)
   localparam int GPIO_MAX_PORTS = 8;

   // Port index of an address relative to the block base (base is 4-aligned)
   function automatic logic [2:0] gpio_port_idx(input logic [7:0] addr,
                                                input logic [7:0] base);
      logic [7:0] rel;
      rel = addr - base;
      return rel[4:2];
   endfunction

endpackage

// File: rtl/ip_gpio_port.sv
// One 8-bit GPIO port: output latch, direction, input synchroniser,
// rising-edge status with write-1-to-clear, interrupt enable and read mux.
module ip_gpio_port
   import ip_gpio_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       wr_en,
   input  logic [1:0] offset,
   input  logic [7:0] wdata,
   input  logic [7:0] gpi,
   output logic [7:0] gpo,
   output logic [7:0] gpo_oe,
   output logic [7:0] rdata,
   output logic       irq_local
);

   logic [7:0]                  data_q, data_d;
   logic [7:0]                  dir_q, dir_d;
   logic [7:0]                  stat_q, stat_d;
   logic [7:0]                  ien_q, ien_d;
   logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
   logic [7:0]                  prev_q, prev_d;
   logic [7:0]                  sync_now;
   logic [7:0]                  rise;
   logic [7:0]                  clr_mask;

   assign sync_now = sync_q[SYNC_STAGES-1];
   // prev tracks the synchronised pin regardless of direction, so a DIR
   // change never fabricates an edge.
   assign rise     = sync_now & ~prev_q & ~dir_q;

   // Next-state: register writes, synchroniser shift, edge capture (set beats clear)
   always_comb begin
      data_d   = data_q;
      dir_d    = dir_q;
      ien_d    = ien_q;
      clr_mask = 8'h00;
      if (wr_en) begin
         case (offset)
            GPIO_DATA: data_d   = wdata;
            GPIO_DIR:  dir_d    = wdata;
            GPIO_STAT: clr_mask = wdata;
            default:   ien_d    = wdata;
         endcase
      end
      stat_d = (stat_q & ~clr_mask) | rise;
      sync_d = {sync_q[SYNC_STAGES-2:0], gpi};
      prev_d = sync_now;
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         data_q <= '0;
         dir_q  <= '0;
         stat_q <= '0;
         ien_q  <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         data_q <= data_d;
         dir_q  <= dir_d;
         stat_q <= stat_d;
         ien_q  <= ien_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   // Read view of the selected register; DATA mixes latch and pin by direction
   always_comb begin
      case (offset)
         GPIO_DATA: rdata = (data_q & dir_q) | (sync_now & ~dir_q);
         GPIO_DIR:  rdata = dir_q;
         GPIO_STAT: rdata = stat_q;
         default:   rdata = ien_q;
      endcase
   end

   assign gpo       = data_q;
   assign gpo_oe    = dir_q;
   assign irq_local = |(stat_q & ien_q);

endmodule

// File: rtl/ip_gpio_multi.sv
// Multi-port GPIO bus slave: address decode, per-port instances,
// registered read response (one-cycle ready pulse) and registered IRQ.
module ip_gpio_multi
   import ip_gpio_pkg::*;
#(
   parameter logic [7:0] IO_BASE     = 8'h10,
   parameter int         PORTS       = 2,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic [15:0]          bus_address,
   input  logic                 bus_io_read,
   input  logic                 bus_io_write,
   input  logic [7:0]           bus_write_data,
   output logic                 bus_read_ready,
   output logic [7:0]           bus_read_data,
   output logic [8*PORTS-1:0]   gpo,
   output logic [8*PORTS-1:0]   gpo_oe,
   input  logic [8*PORTS-1:0]   gpi,
   output logic                 irq
);

   localparam logic [8:0] ADDR_END = 9'(IO_BASE) + 9'(4 * PORTS);

   if (PORTS < 1 || PORTS > GPIO_MAX_PORTS) begin : g_bad_ports
      $error("ip_gpio_multi: PORTS must be 1..8");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("ip_gpio_multi: SYNC_STAGES must be 2..4");
   end
   if (IO_BASE[1:0] != 2'b00) begin : g_bad_align
      $error("ip_gpio_multi: IO_BASE must be a multiple of 4");
   end
   if (32'(IO_BASE) + 4 * PORTS > 256) begin : g_bad_range
      $error("ip_gpio_multi: register window exceeds the 8-bit I/O space");
   end

   logic [7:0]            addr8;
   logic                  hit;
   logic [2:0]            port_idx;
   logic [PORTS-1:0][7:0] port_rdata;
   logic [PORTS-1:0]      port_irq;
   logic [7:0]            rd_mux;
   logic                  unused_addr_hi;

   logic                  rd_valid_q, rd_valid_d;
   logic [7:0]            rd_data_q, rd_data_d;
   logic                  irq_q, irq_d;

   assign addr8          = bus_address[7:0];
   assign unused_addr_hi = ^bus_address[15:8];
   assign hit            = ({1'b0, addr8} >= {1'b0, IO_BASE}) && ({1'b0, addr8} < ADDR_END);
   assign port_idx       = gpio_port_idx(addr8, IO_BASE);

   for (genvar p = 0; p < PORTS; p++) begin : g_port
      logic wr_sel;
      assign wr_sel = bus_io_write && hit && (port_idx == 3'(p));
      ip_gpio_port #(.SYNC_STAGES(SYNC_STAGES)) u_port (
         .clk       (clk),
         .n_reset   (n_reset),
         .wr_en     (wr_sel),
         .offset    (addr8[1:0]),
         .wdata     (bus_write_data),
         .gpi       (gpi[8*p +: 8]),
         .gpo       (gpo[8*p +: 8]),
         .gpo_oe    (gpo_oe[8*p +: 8]),
         .rdata     (port_rdata[p]),
         .irq_local (port_irq[p])
      );
   end

   // Select the addressed port's read value and prepare the response/IRQ flops
   always_comb begin
      rd_mux = 8'h00;
      for (int p = 0; p < PORTS; p++) begin
         if (port_idx == 3'(p)) rd_mux = port_rdata[p];
      end
      rd_valid_d = bus_io_read && hit;
      rd_data_d  = rd_valid_d ? rd_mux : 8'h00;
      irq_d      = |port_irq;
   end

   // Response and IRQ registers; reset kills any pending read at once
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= 8'h00;
         irq_q      <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         irq_q      <= irq_d;
      end
   end

   assign bus_read_ready = rd_valid_q;
   assign bus_read_data  = rd_data_q;
   assign irq            = irq_q;

endmodule

// File: tb/tb_ip_gpio_multi.sv
// Directed bench for ip_gpio_multi (IO_BASE=8'h10, PORTS=2, SYNC_STAGES=2).
module tb_ip_gpio_multi;

   localparam int SYNC_STAGES = 2;

   logic        clk;
   logic        n_reset;
   logic [15:0] bus_address;
   logic        bus_io_read;
   logic        bus_io_write;
   logic [7:0]  bus_write_data;
   logic        bus_read_ready;
   logic [7:0]  bus_read_data;
   logic [15:0] gpo;
   logic [15:0] gpo_oe;
   logic [15:0] gpi;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   ip_gpio_multi #(
      .IO_BASE     (8'h10),
      .PORTS       (2),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk            (clk),
      .n_reset        (n_reset),
      .bus_address    (bus_address),
      .bus_io_read    (bus_io_read),
      .bus_io_write   (bus_io_write),
      .bus_write_data (bus_write_data),
      .bus_read_ready (bus_read_ready),
      .bus_read_data  (bus_read_data),
      .gpo            (gpo),
      .gpo_oe         (gpo_oe),
      .gpi            (gpi),
      .irq            (irq)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clk);
      bus_address    = addr;
      bus_write_data = data;
      bus_io_write   = 1'b1;
      @(negedge clk);
      bus_io_write   = 1'b0;
      bus_address    = 16'h0000;
      bus_write_data = 8'h00;
   endtask

   task automatic bus_read(input logic [15:0] addr, input logic [7:0] exp, input string tag);
      exp_q.push_back(exp);
      @(negedge clk);
      bus_address = addr;
      bus_io_read = 1'b1;
      @(posedge clk);
      #1;
      bus_io_read = 1'b0;
      bus_address = 16'h0000;
      check({tag, "_rdy"}, 16'(bus_read_ready), 16'h0001);
      check(tag, 16'(bus_read_data), 16'(exp_q.pop_front()));
   endtask

   initial begin
      logic seen_ready;
      logic [7:0] seen_data;

      n_reset        = 1'b0;
      bus_address    = 16'h0000;
      bus_io_read    = 1'b0;
      bus_io_write   = 1'b0;
      bus_write_data = 8'h00;
      gpi            = 16'h0000;
      repeat (3) @(negedge clk);
      check("rst_gpo", gpo, 16'h0000);
      check("rst_oe", gpo_oe, 16'h0000);
      check("rst_irq", 16'(irq), 16'h0000);
      check("rst_rdy", 16'(bus_read_ready), 16'h0000);
      check("rst_rdata", 16'(bus_read_data), 16'h0000);
      n_reset = 1'b1;
      @(negedge clk);

      // 1: port0 latch and direction
      bus_write(16'h0010, 8'h12);
      check("t1_gpo", gpo, 16'h0012);
      bus_write(16'h0011, 8'hFF);
      check("t1_oe", gpo_oe, 16'h00FF);

      // 2: port1 DATA with upper address bits set, readback once driven
      bus_write(16'hCD14, 8'hAB);
      check("t2_gpo", gpo, 16'hAB12);
      bus_write(16'h0015, 8'hFF);
      bus_read(16'h0014, 8'hAB, "t2_rd_data1");
      @(posedge clk); #1;
      check("t2_rdy_drop", 16'(bus_read_ready), 16'h0000);
      check("t2_rdata_zero", 16'(bus_read_data), 16'h0000);
      bus_read(16'h0015, 8'hFF, "t2_rd_dir1");

      // 3: mixed direction read, output-direction bits never flag edges
      bus_write(16'h0011, 8'h0F);
      bus_write(16'h0010, 8'hA5);
      @(negedge clk);
      gpi = 16'h003C;
      repeat (SYNC_STAGES + 1) @(negedge clk);
      bus_read(16'h0010, 8'h35, "t3_rd_data0");
      bus_read(16'h0012, 8'h30, "t3_rd_stat0");
      bus_write(16'h0012, 8'hFF);
      bus_read(16'h0012, 8'h00, "t3_stat_clr");

      // 4: DIR 1->0 with pins already high gives no edge; real rise sets STAT and irq
      bus_write(16'h0011, 8'h00);
      bus_write(16'h0013, 8'h01);
      bus_read(16'h0013, 8'h01, "t4_rd_ien0");
      check("t4_irq_idle", 16'(irq), 16'h0000);
      @(negedge clk);
      gpi = 16'h003D;
      repeat (SYNC_STAGES + 3) @(negedge clk);
      bus_read(16'h0012, 8'h01, "t4_rd_stat0");
      check("t4_irq_set", 16'(irq), 16'h0001);
      bus_write(16'h0012, 8'h01);
      check("t4_irq_lag", 16'(irq), 16'h0001);
      @(negedge clk);
      check("t4_irq_clr", 16'(irq), 16'h0000);
      bus_read(16'h0012, 8'h00, "t4_stat_clr");

      // 5: edge set and W1C of the same bit in the same cycle
      @(negedge clk);
      gpi = 16'h003C;
      repeat (SYNC_STAGES + 2) @(negedge clk);
      gpi = 16'h003D;
      repeat (SYNC_STAGES) @(negedge clk);
      bus_address    = 16'h0012;
      bus_write_data = 8'h01;
      bus_io_write   = 1'b1;
      @(negedge clk);
      bus_io_write   = 1'b0;
      bus_address    = 16'h0000;
      @(negedge clk);
      check("t5_irq", 16'(irq), 16'h0001);
      bus_read(16'h0012, 8'h01, "t5_stat_kept");
      bus_write(16'h0012, 8'h01);
      @(negedge clk);
      check("t5_irq_clr", 16'(irq), 16'h0000);

      // read and write of the same register in one cycle: read sees old value
      @(negedge clk);
      bus_address    = 16'h0014;
      bus_write_data = 8'h5A;
      bus_io_read    = 1'b1;
      bus_io_write   = 1'b1;
      @(posedge clk); #1;
      bus_io_read  = 1'b0;
      bus_io_write = 1'b0;
      bus_address  = 16'h0000;
      check("rw_rdy", 16'(bus_read_ready), 16'h0001);
      check("rw_old", 16'(bus_read_data), 16'h00AB);
      check("rw_gpo", gpo, 16'h5AA5);

      // 6: misses never respond and never write
      seen_ready = 1'b0;
      seen_data  = 8'h00;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus_address = (i % 2 == 0) ? 16'h0002 : 16'h0018;
         bus_io_read = 1'b1;
         @(posedge clk); #1;
         seen_ready = seen_ready | bus_read_ready;
         seen_data  = seen_data | bus_read_data;
      end
      bus_io_read = 1'b0;
      @(posedge clk); #1;
      seen_ready = seen_ready | bus_read_ready;
      check("t6_no_ready", 16'(seen_ready), 16'h0000);
      check("t6_no_data", 16'(seen_data), 16'h0000);
      bus_write(16'h0018, 8'hFF);
      bus_write(16'h000F, 8'hFF);
      bus_write(16'h0002, 8'hFF);
      check("t6_gpo", gpo, 16'h5AA5);
      check("t6_oe", gpo_oe, 16'hFF00);
      bus_read(16'h0017, 8'h00, "t6_last_reg");

      // reset in the middle of a read response
      @(negedge clk);
      bus_address = 16'h0010;
      bus_io_read = 1'b1;
      @(posedge clk); #1;
      bus_io_read = 1'b0;
      check("mr_rdy", 16'(bus_read_ready), 16'h0001);
      n_reset = 1'b0;
      #1;
      check("mr_rdy_drop", 16'(bus_read_ready), 16'h0000);
      check("mr_gpo", gpo, 16'h0000);
      check("mr_oe", gpo_oe, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
